// File: rtl/kfps2kb_key_fifo.sv
// ---------------------------------------------------------------------------------------------
// kfps2kb_key_fifo
//
// Keycode buffer between the XT-code converter (upstream) and the host-side keycode consumer.
// Upstream keycodes arrive on a level irq/clear handshake. Each one is captured exactly once
// into a DEPTH-entry circular FIFO. Buffered keycodes are then re-presented to the host one at a
// time on the same style of level irq/clear handshake. Keyboard bursts survive a slow host. A
// keycode that finds the FIFO full is dropped and flagged in a sticky overflow bit.
//
// All state updates on the FALLING edge of clock. reset_n is an asynchronous active-low reset.
//
// Ports
//   clock          in   system clock (falling-edge active)
//   reset_n        in   asynchronous active-low reset
//   flush          in   synchronous clear of FIFO, output stage and overflow
//   src_irq        in   upstream keycode valid (level, held until src_clear seen)
//   src_keycode    in   upstream keycode, stable while src_irq=1
//   src_clear      out  capture acknowledge to upstream (level)
//   irq            out  keycode available to host (level)
//   keycode        out  keycode presented to host, stable while irq=1
//   clear_keycode  in   host acknowledge (level)
//   overflow       out  sticky: a keycode was dropped because the FIFO was full
//   count          out  FIFO occupancy 0..DEPTH, excluding the presented keycode
// ---------------------------------------------------------------------------------------------

module kfps2kb_key_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          src_irq,
    input  logic [7:0]    src_keycode,
    output logic          src_clear,
    output logic          irq,
    output logic [7:0]    keycode,
    input  logic          clear_keycode,
    output logic          overflow,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    typedef enum logic {
        CapIdle,
        CapAck
    } cap_state_e;

    typedef enum logic [1:0] {
        OutIdle,
        OutPresent,
        OutRelease
    } out_state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    cap_state_e      cap_state_q, cap_state_d;
    out_state_e      out_state_q, out_state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      keycode_q, keycode_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    // -----------------------------------------------------------------------------------------
    // FIFO control
    // -----------------------------------------------------------------------------------------
    logic push_req;  // upstream offers a keycode this cycle (first cycle of its irq only)
    logic pop;
    logic push;
    logic drop;
    logic full;

    always_comb begin
        full     = (count_q == FullCount);
        push_req = (cap_state_q == CapIdle) && src_irq;
        // The pop decision does not depend on push, so a full FIFO can still accept a keycode
        // in the same cycle the head is moved into the output register.
        pop      = (out_state_q == OutIdle) && (count_q != '0) && !clear_keycode && !flush;
        push     = push_req && (!full || pop) && !flush;
        drop     = push_req && full && !pop && !flush;
    end

    // -----------------------------------------------------------------------------------------
    // Capture FSM: one push per upstream irq assertion. A dropped keycode is still acknowledged
    // so the upstream converter never stalls.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        cap_state_d = cap_state_q;
        unique case (cap_state_q)
            CapIdle: begin
                if (src_irq) begin
                    cap_state_d = CapAck;
                end
            end
            CapAck: begin
                if (!src_irq) begin
                    cap_state_d = CapIdle;
                end
            end
            default: cap_state_d = CapIdle;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Output FSM: the presented keycode leaves the FIFO on pop; OutRelease waits for the host
    // to drop clear_keycode so a held acknowledge retires only one keycode.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        out_state_d = out_state_q;
        keycode_d   = keycode_q;
        if (flush) begin
            out_state_d = OutIdle;
        end else begin
            unique case (out_state_q)
                OutIdle: begin
                    if (pop) begin
                        keycode_d   = mem_q[rd_ptr_q];
                        out_state_d = OutPresent;
                    end
                end
                OutPresent: begin
                    if (clear_keycode) begin
                        out_state_d = OutRelease;
                    end
                end
                OutRelease: begin
                    if (!clear_keycode) begin
                        out_state_d = OutIdle;
                    end
                end
                default: out_state_d = OutIdle;
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow. Pointers wrap naturally since DEPTH is 2**AW.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = src_keycode;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Registers (falling edge)
    // -----------------------------------------------------------------------------------------
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cap_state_q <= CapIdle;
            out_state_q <= OutIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            keycode_q   <= 8'h00;
        end else begin
            cap_state_q <= cap_state_d;
            out_state_q <= out_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            keycode_q   <= keycode_d;
        end
    end

    // Storage is only ever read after being written, so it needs no reset.
    always_ff @(negedge clock) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign src_clear = (cap_state_q == CapAck);
    assign irq       = (out_state_q == OutPresent);
    assign keycode   = keycode_q;
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_kfps2kb_key_fifo.sv
module tb_kfps2kb_key_fifo;

    localparam int unsigned DEPTH = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       src_irq = 1'b0;
    logic [7:0] src_keycode = 8'h00;
    logic       src_clear;
    logic       irq;
    logic [7:0] keycode;
    logic       clear_keycode = 1'b0;
    logic       overflow;
    logic [3:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    kfps2kb_key_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .flush        (flush),
        .src_irq      (src_irq),
        .src_keycode  (src_keycode),
        .src_clear    (src_clear),
        .irq          (irq),
        .keycode      (keycode),
        .clear_keycode(clear_keycode),
        .overflow     (overflow),
        .count        (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       flush;
        logic       src_irq;
        logic [7:0] src_kc;
        logic       clr;
        logic       e_sc;
        logic       e_irq;
        logic [7:0] e_kc;
        logic [3:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic f, input logic s, input logic [7:0] k, input logic c,
                       input logic esc, input logic eirq, input logic [7:0] ekc,
                       input logic [3:0] ecnt, input logic eovf);
        vec_t v;
        v.flush = f; v.src_irq = s; v.src_kc = k; v.clr = c;
        v.e_sc = esc; v.e_irq = eirq; v.e_kc = ekc; v.e_cnt = ecnt; v.e_ovf = eovf;
        vecs.push_back(v);
    endtask

    // Active edge is the falling edge; sample 1 time unit after it.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic check_out(input string name, input logic esc, input logic eirq,
                             input logic [7:0] ekc, input logic [3:0] ecnt, input logic eovf);
        n_checks++;
        if ({src_clear, irq, keycode, count, overflow} !== {esc, eirq, ekc, ecnt, eovf}) begin
            n_fail++;
            $display("FAIL %s: got sc=%0b irq=%0b kc=%02h cnt=%0d ovf=%0b, want sc=%0b irq=%0b kc=%02h cnt=%0d ovf=%0b",
                     name, src_clear, irq, keycode, count, overflow, esc, eirq, ekc, ecnt, eovf);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_key(input logic [7:0] k);
        src_keycode = k;
        src_irq = 1'b1;
        step();
        src_irq = 1'b0;
        step();
    endtask

    // Host ack; leaves the output FSM in idle so the next step() may pop.
    task automatic ack();
        clear_keycode = 1'b1;
        step();
        clear_keycode = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        flush = 1'b0; src_irq = 1'b0; clear_keycode = 1'b0; src_keycode = 8'h00;
        #2;
        reset_n = 1'b1;
    endtask

    logic [7:0] exp_seq[$];

    initial begin
        // ---------------- reset state ----------------
        #3;
        check_out("reset_init", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        #1;
        reset_n = 1'b1;

        // ---------------- table: single key, burst, held irq, flush+push ----------------
        add(0, 1, 8'h1E, 0,  1, 0, 8'h00, 1, 0); // 0 capture
        add(0, 0, 8'h00, 0,  0, 1, 8'h1E, 0, 0); // 1 present
        add(0, 0, 8'h00, 1,  0, 0, 8'h1E, 0, 0); // 2 ack
        add(0, 0, 8'h00, 0,  0, 0, 8'h1E, 0, 0); // 3 release
        add(0, 1, 8'h1E, 0,  1, 0, 8'h1E, 1, 0); // 4 burst 1E
        add(0, 0, 8'h00, 0,  0, 1, 8'h1E, 0, 0); // 5
        add(0, 1, 8'h9E, 0,  1, 1, 8'h1E, 1, 0); // 6 9E
        add(0, 0, 8'h00, 0,  0, 1, 8'h1E, 1, 0); // 7
        add(0, 1, 8'hE0, 0,  1, 1, 8'h1E, 2, 0); // 8 E0
        add(0, 0, 8'h00, 0,  0, 1, 8'h1E, 2, 0); // 9
        add(0, 1, 8'h48, 0,  1, 1, 8'h1E, 3, 0); // 10 48
        add(0, 0, 8'h00, 0,  0, 1, 8'h1E, 3, 0); // 11
        add(0, 0, 8'h00, 1,  0, 0, 8'h1E, 3, 0); // 12 ack 1E
        add(0, 0, 8'h00, 0,  0, 0, 8'h1E, 3, 0); // 13
        add(0, 0, 8'h00, 0,  0, 1, 8'h9E, 2, 0); // 14
        add(0, 0, 8'h00, 1,  0, 0, 8'h9E, 2, 0); // 15
        add(0, 0, 8'h00, 0,  0, 0, 8'h9E, 2, 0); // 16
        add(0, 0, 8'h00, 0,  0, 1, 8'hE0, 1, 0); // 17
        add(0, 0, 8'h00, 1,  0, 0, 8'hE0, 1, 0); // 18
        add(0, 0, 8'h00, 0,  0, 0, 8'hE0, 1, 0); // 19
        add(0, 0, 8'h00, 0,  0, 1, 8'h48, 0, 0); // 20
        add(0, 0, 8'h00, 1,  0, 0, 8'h48, 0, 0); // 21
        add(0, 0, 8'h00, 0,  0, 0, 8'h48, 0, 0); // 22
        add(0, 1, 8'h77, 0,  1, 0, 8'h48, 1, 0); // 23 src_irq held high
        add(0, 1, 8'h77, 0,  1, 1, 8'h77, 0, 0); // 24
        add(0, 1, 8'h77, 0,  1, 1, 8'h77, 0, 0); // 25 no second push
        add(0, 0, 8'h00, 0,  0, 1, 8'h77, 0, 0); // 26
        add(0, 0, 8'h00, 1,  0, 0, 8'h77, 0, 0); // 27
        add(0, 0, 8'h00, 0,  0, 0, 8'h77, 0, 0); // 28
        add(1, 1, 8'h66, 0,  1, 0, 8'h77, 0, 0); // 29 flush discards push
        add(0, 0, 8'h00, 0,  0, 0, 8'h77, 0, 0); // 30
        add(0, 0, 8'h00, 0,  0, 0, 8'h77, 0, 0); // 31

        for (int i = 0; i < vecs.size(); i++) begin
            flush = vecs[i].flush;
            src_irq = vecs[i].src_irq;
            src_keycode = vecs[i].src_kc;
            clear_keycode = vecs[i].clr;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].e_sc, vecs[i].e_irq, vecs[i].e_kc,
                      vecs[i].e_cnt, vecs[i].e_ovf);
        end
        flush = 1'b0; src_irq = 1'b0; clear_keycode = 1'b0;

        // ---------------- overflow ----------------
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            push_key(8'(k));
        end
        check_out("ovf_full", 1'b0, 1'b1, 8'h01, 4'd8, 1'b1);
        for (int k = 2; k <= 9; k++) begin
            ack();
            step();
            check_val($sformatf("ovf_deliver_%0d", k), {23'd0, irq, keycode}, {23'd1, 8'(k)});
        end
        ack();
        step();
        step();
        check_out("ovf_drained", 1'b0, 1'b0, 8'h09, 4'd0, 1'b1);

        // ---------------- flush with count=5, irq=1, overflow=1 ----------------
        for (int k = 1; k <= 6; k++) begin
            push_key(8'(k));
        end
        check_out("flush_pre", 1'b0, 1'b1, 8'h01, 4'd5, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_out("flush_post", 1'b0, 1'b0, 8'h01, 4'd0, 1'b0);
        step();
        check_out("flush_idle", 1'b0, 1'b0, 8'h01, 4'd0, 1'b0);

        // ---------------- held clear_keycode across two keycodes ----------------
        push_key(8'hAA);
        check_out("sticky_aa", 1'b0, 1'b1, 8'hAA, 4'd0, 1'b0);
        clear_keycode = 1'b1;
        step();
        check_val("sticky_ack_irq", {31'd0, irq}, 32'd0);
        push_key(8'hBB);
        step();
        step();
        check_out("sticky_held", 1'b0, 1'b0, 8'hAA, 4'd1, 1'b0);
        clear_keycode = 1'b0;
        step();
        check_val("sticky_rel_irq", {31'd0, irq}, 32'd0);
        step();
        check_out("sticky_bb", 1'b0, 1'b1, 8'hBB, 4'd0, 1'b0);

        // ---------------- simultaneous push/pop at full ----------------
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            push_key(8'(k));
        end
        check_out("full_pre", 1'b0, 1'b1, 8'h01, 4'd8, 1'b0);
        ack();
        src_keycode = 8'h55;
        src_irq = 1'b1;
        step();
        check_out("full_pushpop", 1'b1, 1'b1, 8'h02, 4'd8, 1'b0);
        src_irq = 1'b0;
        step();
        exp_seq = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h55};
        for (int i = 0; i < exp_seq.size(); i++) begin
            ack();
            step();
            check_val($sformatf("full_deliver_%0d", i), {23'd0, irq, keycode},
                      {23'd1, exp_seq[i]});
        end
        check_val("full_end_cnt", {27'd0, overflow, count}, 32'd0);

        // ---------------- async reset mid-capture ----------------
        ack();
        src_keycode = 8'h33;
        src_irq = 1'b1;
        step();
        step();
        check_out("rst_pre", 1'b1, 1'b1, 8'h33, 4'd0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("rst_async", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        src_irq = 1'b0;
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kfps2kb_key_fifo.md
# kfps2kb_key_fifo

- Keycode buffering controller between the XT-code converter and the host-side keycode consumer.
- Sequences the converter's irq/clear handshake and captures each keycode into a DEPTH-entry FIFO.
- Re-presents buffered keycodes to the host one at a time using the same level irq/clear handshake.
- Bursts from the keyboard (make/break prefixes, typematic repeat) are not lost while the host is slow to acknowledge; overflow is flagged.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH), FIFO pointer width (derived, not overridden).
- clock  in  1  system clock; all registers update on its falling edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO, output stage and overflow.
- src_irq  in  1  upstream keycode valid; level, held until upstream sees src_clear.
- src_keycode  in  8  upstream keycode, stable while src_irq=1.
- src_clear  out  1  capture acknowledge to upstream; level.
- irq  out  1  keycode available to host; level.
- keycode  out  8  keycode presented to host; stable while irq=1.
- clear_keycode  in  1  host acknowledge; level.
- overflow  out  1  sticky; a keycode was dropped because the FIFO was full.
- count  out  AW+1  FIFO occupancy, 0..DEPTH; excludes the presented keycode.

## Operation
- Reset (reset_n=0, asynchronous):
  - src_clear=0, irq=0, keycode=8'h00, overflow=0, count=0.
  - Both FSMs in IDLE; pointers 0.
- Capture FSM, states CAP_IDLE and CAP_ACK:
  - CAP_IDLE, src_irq=1: push src_keycode, go to CAP_ACK with src_clear=1.
  - Push condition: count<DEPTH, or a pop happens in the same cycle.
  - If the push is not possible, the keycode is dropped, overflow is set to 1, and the FSM still goes to CAP_ACK.
  - CAP_ACK: src_clear held at 1 while src_irq=1. When src_irq=0, go to CAP_IDLE with src_clear=0.
  - Result: exactly one push per upstream irq assertion.
- Output FSM, states OUT_IDLE, OUT_PRESENT and OUT_RELEASE:
  - OUT_IDLE, count>0 (and clear_keycode=0): pop the head into the keycode register, set irq=1, go to OUT_PRESENT.
  - OUT_PRESENT, clear_keycode=1: set irq=0, go to OUT_RELEASE. The keycode register holds its value.
  - OUT_RELEASE, clear_keycode=0: go to OUT_IDLE.
  - A held-high clear_keycode therefore acknowledges only one keycode.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of AW bits, wrapping DEPTH-1→0.
  - count is a separate AW+1-bit counter.
  - Simultaneous push and pop leaves count unchanged.
  - Push at count=DEPTH with a simultaneous pop is accepted.
- Order: keycodes reach the host in capture order, with no duplicates and no reordering.
- flush=1 (takes effect at the next falling edge, has priority over push/pop):
  - Pointers and count go to 0, overflow=0, output FSM goes to OUT_IDLE, irq=0. The keycode register is held.
  - A push in the same cycle is discarded.
  - The capture FSM is not reset; its src_irq handshake completes normally.
- overflow is cleared only by reset or flush.

## Timing
- Capture: src_irq sampled 1 at edge N → src_clear=1 and count incremented after edge N.
- Capture release: src_irq sampled 0 at edge M → src_clear=0 after edge M.
- Capture to host: FIFO empty and OUT_IDLE, push at edge N → pop, irq=1 and keycode valid after edge N+1. Latency is 2 edges from src_irq.
- Host acknowledge: clear_keycode sampled 1 at edge K → irq=0 after K.
- Back-to-back delivery: next keycode earliest at edge K+2, requiring clear_keycode=0 sampled at K+1.
- Host back-to-back rate: 1 keycode per 3 clocks. Upstream rate: 1 keycode per 2 clocks.
- All inputs are assumed synchronous to clock; no internal synchronisers.

## Test plan
- Reset check: drive reset_n=0 mid-capture, with src_clear=1 and irq=1 → all outputs return to their reset values immediately, without a clock edge.
- Single key: src_keycode=8'h1E with the src_irq handshake → src_clear=1 one edge later; irq=1 with keycode=8'h1E one edge after that; clear_keycode=1 → irq=0; count ends at 0.
- Burst ordering: push 8'h1E, 8'h9E, 8'hE0, 8'h48 with clear_keycode held 0 → count=3 and keycode=8'h1E. Host acks deliver 9E, E0 and 48 in that order; count reaches 0.
- Overflow, DEPTH=8: push 10 keycodes 8'h01..8'h0A with no host ack → 01 is presented, FIFO holds 02..09 (count=8), 0A is dropped and overflow=1. Subsequent acks deliver 02..09 only.
- Simultaneous push/pop at full: FIFO at count=8, host ack causes a pop on the same edge as push 8'h55 → count stays 8, overflow stays 0, and 55 is delivered last.
- Flush and sticky handshake:
  - flush while count=5 and irq=1 → count=0, irq=0, overflow=0.
  - Then clear_keycode held 1 across two new keycodes → only the first is presented until clear_keycode returns to 0.
